eye_monitor_width_trainer: RTL and testbench

//  Fabric-side training controller downstream of the clock-training IOD.

---
 rtl/eye_mon_train_pkg.sv | 36 +++
 rtl/eye_mon_flag_sync.sv | 26 ++
 rtl/eye_monitor_width_trainer.sv | 232 +++++++++++++++++++++++
 tb/tb_eye_monitor_width_trainer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eye_mon_train_pkg.sv
// Shared types and constants for the eye-monitor width trainer.
package eye_mon_train_pkg;

    localparam int WIDTH_W    = 3;
    localparam int NUM_WIDTHS = 8;

    localparam logic [1:0] SKEW_NONE  = 2'b00;
    localparam logic [1:0] SKEW_EARLY = 2'b01;
    localparam logic [1:0] SKEW_LATE  = 2'b10;
    localparam logic [1:0] SKEW_BOTH  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        SETTLE,
        SAMPLE,
        NEXT,
        EVAL,
        DONE,
        ERR,
        MON
    } state_t;

    // Returns {found, index} of the lowest set bit; the high-to-low scan lets the lowest win.
    function automatic logic [WIDTH_W:0] first_fail(input logic [NUM_WIDTHS-1:0] fails);
        logic [WIDTH_W:0] r;
        r = '0;
        for (int i = NUM_WIDTHS - 1; i >= 0; i--) begin
            if (fails[i]) begin
                r = {1'b1, WIDTH_W'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/eye_mon_flag_sync.sv
// Two-flop synchroniser bringing the IOD EARLY/LATE flags into the FAB_CLK domain.
module eye_mon_flag_sync (
    input  logic       FAB_CLK,
    input  logic       FAB_RST_N,
    input  logic [1:0] flags_in,
    output logic [1:0] flags_sync
);

    logic [1:0] meta_reg;
    logic [1:0] sync_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bit
        always_ff @(posedge FAB_CLK) begin
            if (!FAB_RST_N) begin
                meta_reg[gi] <= 1'b0;
                sync_reg[gi] <= 1'b0;
            end else begin
                meta_reg[gi] <= flags_in[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign flags_sync = sync_reg;

endmodule

// File: rtl/eye_monitor_width_trainer.sv
// Sweeps the IOD eye-monitor width 0..7, records EARLY/LATE maps and selects the widest clean width.
// Optional continuous tracking in DONE is enabled by defining EYE_MON_CONT_TRACK_EN.
module eye_monitor_width_trainer
    import eye_mon_train_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 256,
    parameter int MON_PERIOD    = 4096
) (
    input  logic               FAB_CLK,
    input  logic               FAB_RST_N,
    input  logic               TRAIN_START,
    input  logic               EYE_MONITOR_EARLY_0,
    input  logic               EYE_MONITOR_LATE_0,
    output logic               EYE_MONITOR_CLEAR_FLAGS_0,
    output logic [WIDTH_W-1:0] EYE_MONITOR_LANE_WIDTH,
    output logic               TRAIN_BUSY,
    output logic               TRAIN_DONE,
    output logic               TRAIN_ERR,
    output logic [WIDTH_W-1:0] EYE_WIDTH_RESULT,
    output logic [NUM_WIDTHS-1:0] EARLY_MAP,
    output logic [NUM_WIDTHS-1:0] LATE_MAP,
    output logic [1:0]         SKEW_DIR,
    output logic               RETRAIN_REQ
);

    localparam int CNT_MAX_SS = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_SS > MON_PERIOD) ? CNT_MAX_SS : MON_PERIOD;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [WIDTH_W-1:0] LAST_WIDTH  = WIDTH_W'(NUM_WIDTHS - 1);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [WIDTH_W-1:0]      w_reg, w_next;
    logic                    start_reg;
    logic                    e_seen_reg, e_seen_next;
    logic                    l_seen_reg, l_seen_next;
    logic [NUM_WIDTHS-1:0]   early_map_reg, early_map_next;
    logic [NUM_WIDTHS-1:0]   late_map_reg, late_map_next;
    logic [WIDTH_W-1:0]      result_reg, result_next;
    logic [1:0]              skew_reg, skew_next;
    logic [1:0]              flags_sync;
    logic                    early_sync, late_sync;
    logic                    track;
    logic                    can_start;
    logic                    done_level;
    logic [WIDTH_W:0]        ff;
    logic [WIDTH_W-1:0]      fidx;

    eye_mon_flag_sync u_flag_sync (
        .FAB_CLK    (FAB_CLK),
        .FAB_RST_N  (FAB_RST_N),
        .flags_in   ({EYE_MONITOR_LATE_0, EYE_MONITOR_EARLY_0}),
        .flags_sync (flags_sync)
    );
    assign early_sync = flags_sync[0];
    assign late_sync  = flags_sync[1];

`ifdef EYE_MON_CONT_TRACK_EN
    localparam logic [CNT_W-1:0] MON_LOAD = CNT_W'(MON_PERIOD - 1);
    logic track_reg, track_next;
    logic retrain_reg, retrain_next;

    always_ff @(posedge FAB_CLK) begin
        if (!FAB_RST_N) begin
            track_reg   <= 1'b0;
            retrain_reg <= 1'b0;
        end else begin
            track_reg   <= track_next;
            retrain_reg <= retrain_next;
        end
    end
    assign track       = track_reg;
    assign RETRAIN_REQ = retrain_reg;
`else
    assign track       = 1'b0;
    assign RETRAIN_REQ = 1'b0;
`endif

    // The tracking loop reuses CLEAR/SETTLE/SAMPLE but is logically part of DONE.
    assign can_start = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR) || track;
    assign ff        = first_fail(early_map_reg | late_map_reg);
    assign fidx      = ff[WIDTH_W-1:0];

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        w_next         = w_reg;
        e_seen_next    = e_seen_reg;
        l_seen_next    = l_seen_reg;
        early_map_next = early_map_reg;
        late_map_next  = late_map_reg;
        result_next    = result_reg;
        skew_next      = skew_reg;
`ifdef EYE_MON_CONT_TRACK_EN
        track_next     = track_reg;
        retrain_next   = retrain_reg;
`endif
        if (start_reg && can_start) begin
            state_next     = CLEAR;
            w_next         = '0;
            e_seen_next    = 1'b0;
            l_seen_next    = 1'b0;
            early_map_next = '0;
            late_map_next  = '0;
            result_next    = '0;
            skew_next      = SKEW_NONE;
`ifdef EYE_MON_CONT_TRACK_EN
            track_next     = 1'b0;
            retrain_next   = 1'b0;
`endif
        end else begin
            case (state_reg)
                CLEAR: begin
                    state_next = SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end
                SETTLE: begin
                    if (cnt_reg == '0) begin
                        state_next = SAMPLE;
                        cnt_next   = SAMPLE_LOAD;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (!track) begin
                        e_seen_next = e_seen_reg | early_sync;
                        l_seen_next = l_seen_reg | late_sync;
                    end
`ifdef EYE_MON_CONT_TRACK_EN
                    if (track && (early_sync || late_sync)) begin
                        retrain_next = 1'b1;
                    end
`endif
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else if (!track) begin
                        state_next = NEXT;
                    end else begin
`ifdef EYE_MON_CONT_TRACK_EN
                        state_next = MON;
                        cnt_next   = MON_LOAD;
`endif
                    end
                end
                NEXT: begin
                    early_map_next[w_reg] = e_seen_reg;
                    late_map_next[w_reg]  = l_seen_reg;
                    e_seen_next           = 1'b0;
                    l_seen_next           = 1'b0;
                    if (w_reg == LAST_WIDTH) begin
                        state_next = EVAL;
                    end else begin
                        w_next     = w_reg + 1'b1;
                        state_next = CLEAR;
                    end
                end
                EVAL: begin
                    if (!ff[WIDTH_W]) begin
                        result_next = LAST_WIDTH;
                        skew_next   = SKEW_NONE;
                        state_next  = DONE;
                    end else if (fidx == '0) begin
                        skew_next  = {late_map_reg[0], early_map_reg[0]};
                        state_next = ERR;
                    end else begin
                        result_next = fidx - 1'b1;
                        skew_next   = {late_map_reg[fidx], early_map_reg[fidx]};
                        state_next  = DONE;
                    end
                end
`ifdef EYE_MON_CONT_TRACK_EN
                DONE: begin
                    track_next = 1'b1;
                    state_next = MON;
                    cnt_next   = MON_LOAD;
                end
                MON: begin
                    if (cnt_reg == '0) begin
                        state_next = CLEAR;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (!FAB_RST_N) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            w_reg         <= '0;
            start_reg     <= 1'b0;
            e_seen_reg    <= 1'b0;
            l_seen_reg    <= 1'b0;
            early_map_reg <= '0;
            late_map_reg  <= '0;
            result_reg    <= '0;
            skew_reg      <= SKEW_NONE;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            w_reg         <= w_next;
            start_reg     <= TRAIN_START;
            e_seen_reg    <= e_seen_next;
            l_seen_reg    <= l_seen_next;
            early_map_reg <= early_map_next;
            late_map_reg  <= late_map_next;
            result_reg    <= result_next;
            skew_reg      <= skew_next;
        end
    end

    assign done_level                = (state_reg == DONE) || (state_reg == MON) || track;
    assign TRAIN_DONE                = done_level;
    assign TRAIN_ERR                 = (state_reg == ERR);
    assign TRAIN_BUSY                = !track && ((state_reg == CLEAR) || (state_reg == SETTLE) ||
                                       (state_reg == SAMPLE) || (state_reg == NEXT) || (state_reg == EVAL));
    assign EYE_MONITOR_CLEAR_FLAGS_0 = (state_reg == CLEAR);
    assign EYE_MONITOR_LANE_WIDTH    = done_level ? result_reg : (TRAIN_ERR ? '0 : w_reg);
    assign EYE_WIDTH_RESULT          = result_reg;
    assign EARLY_MAP                 = early_map_reg;
    assign LATE_MAP                  = late_map_reg;
    assign SKEW_DIR                  = skew_reg;

endmodule

// File: tb/tb_eye_monitor_width_trainer.sv
// Directed bench for eye_monitor_width_trainer (SETTLE=4, SAMPLE=8, so a sweep takes 114 cycles).
module tb_eye_monitor_width_trainer;

    localparam int LAT = 114;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       early = 1'b0;
    logic       late = 1'b0;
    logic       clear_flags;
    logic [2:0] lane_width;
    logic       busy, done, err, retrain;
    logic [2:0] result;
    logic [7:0] early_map, late_map;
    logic [1:0] skew;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mode = 0;
    int cyc_cnt = 0;
    int start_cyc = 0;
    int rel;
    logic [2:0] clr_q[$];

    eye_monitor_width_trainer #(
        .SETTLE_CYCLES(4),
        .SAMPLE_CYCLES(8),
        .MON_PERIOD(64)
    ) dut (
        .FAB_CLK                   (clk),
        .FAB_RST_N                 (rst_n),
        .TRAIN_START               (start),
        .EYE_MONITOR_EARLY_0       (early),
        .EYE_MONITOR_LATE_0        (late),
        .EYE_MONITOR_CLEAR_FLAGS_0 (clear_flags),
        .EYE_MONITOR_LANE_WIDTH    (lane_width),
        .TRAIN_BUSY                (busy),
        .TRAIN_DONE                (done),
        .TRAIN_ERR                 (err),
        .EYE_WIDTH_RESULT          (result),
        .EARLY_MAP                 (early_map),
        .LATE_MAP                  (late_map),
        .SKEW_DIR                  (skew),
        .RETRAIN_REQ               (retrain)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // IOD stand-in: logs clear pulses with their width and drives the flags per scenario.
    always @(negedge clk) begin
        if (clear_flags) clr_q.push_back(lane_width);
        rel = cyc_cnt - start_cyc;
        case (mode)
            1: begin early = (lane_width >= 3'd5); late = 1'b0; end
            2: begin early = 1'b0; late = 1'b1; end
            3: begin early = (rel == 53); late = (rel == 53); end
            4: begin early = 1'b1; late = 1'b0; end
            default: begin early = 1'b0; late = 1'b0; end
        endcase
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc_cnt;
    endtask

    task automatic wait_end(output int lat);
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (done || err) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done, err, clear_flags, retrain, lane_width, result, early_map, late_map, skew} !== 29'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b clr=%b rt=%b lw=%0d res=%0d em=%h lm=%h sk=%b, need all 0",
                     busy, done, err, clear_flags, retrain, lane_width, result, early_map, late_map, skew);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done, err, clear_flags} !== 4'b0000)
            $display("FAIL idle_after_reset: got busy=%b done=%b err=%b clr=%b, need 0000", busy, done, err, clear_flags);
        else pass_cnt++;
        $display("reset: outputs idle");
    endtask

    task automatic test_no_flags();
        int lat;
        mode = 0;
        clr_q.delete();
        do_start();
        wait_end(lat);
        total_cnt++; if (lat != LAT) $display("FAIL s1_latency: got %0d need %0d", lat, LAT); else pass_cnt++;
        total_cnt++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0)
            $display("FAIL s1_status: got done=%b err=%b busy=%b need 1 0 0", done, err, busy); else pass_cnt++;
        total_cnt++; if (result !== 3'd7) $display("FAIL s1_result: got %0d need 7", result); else pass_cnt++;
        total_cnt++; if (early_map !== 8'h00 || late_map !== 8'h00)
            $display("FAIL s1_maps: got %h/%h need 00/00", early_map, late_map); else pass_cnt++;
        total_cnt++; if (skew !== 2'b00) $display("FAIL s1_skew: got %b need 00", skew); else pass_cnt++;
        total_cnt++; if (lane_width !== 3'd7) $display("FAIL s1_lane_done: got %0d need 7", lane_width); else pass_cnt++;
        total_cnt++; if (clr_q.size() != 8) $display("FAIL s1_clear_count: got %0d need 8", clr_q.size()); else pass_cnt++;
        for (int i = 0; i < clr_q.size() && i < 8; i++) begin
            total_cnt++;
            if (clr_q[i] !== 3'(i)) $display("FAIL s1_clear_width%0d: got %0d need %0d", i, clr_q[i], i);
            else pass_cnt++;
        end
        $display("s1 no flags: lat=%0d result=%0d clears=%0d", lat, result, clr_q.size());
    endtask

    task automatic test_static_done();
        int n;
        n = clr_q.size();
        repeat (100) @(posedge clk);
        #1;
        total_cnt++; if (clr_q.size() != n) $display("FAIL static_no_clear: got %0d pulses need %0d", clr_q.size(), n); else pass_cnt++;
        total_cnt++; if (retrain !== 1'b0 || done !== 1'b1)
            $display("FAIL static_done: got retrain=%b done=%b need 0 1", retrain, done); else pass_cnt++;
        $display("static done: clears=%0d retrain=%b", clr_q.size(), retrain);
    endtask

    task automatic test_early_high();
        int lat;
        mode = 1;
        do_start();
        wait_end(lat);
        total_cnt++; if (lat != LAT) $display("FAIL s2_latency: got %0d need %0d", lat, LAT); else pass_cnt++;
        total_cnt++; if (early_map !== 8'hE0 || late_map !== 8'h00)
            $display("FAIL s2_maps: got %h/%h need e0/00", early_map, late_map); else pass_cnt++;
        total_cnt++; if (result !== 3'd4 || done !== 1'b1) $display("FAIL s2_result: got %0d done=%b need 4 1", result, done); else pass_cnt++;
        total_cnt++; if (skew !== 2'b01) $display("FAIL s2_skew: got %b need 01", skew); else pass_cnt++;
        total_cnt++; if (lane_width !== 3'd4) $display("FAIL s2_lane: got %0d need 4", lane_width); else pass_cnt++;
        $display("s2 early>=5: em=%h result=%0d skew=%b", early_map, result, skew);
    endtask

    task automatic test_late_err();
        int lat;
        mode = 2;
        do_start();
        wait_end(lat);
        total_cnt++; if (lat != LAT) $display("FAIL s3_latency: got %0d need %0d", lat, LAT); else pass_cnt++;
        total_cnt++; if (err !== 1'b1 || done !== 1'b0) $display("FAIL s3_status: got err=%b done=%b need 1 0", err, done); else pass_cnt++;
        total_cnt++; if (late_map !== 8'hFF || early_map !== 8'h00)
            $display("FAIL s3_maps: got %h/%h need 00/ff", early_map, late_map); else pass_cnt++;
        total_cnt++; if (skew !== 2'b10) $display("FAIL s3_skew: got %b need 10", skew); else pass_cnt++;
        total_cnt++; if (lane_width !== 3'd0) $display("FAIL s3_lane: got %0d need 0", lane_width); else pass_cnt++;
        $display("s3 late always: err=%b lm=%h skew=%b", err, late_map, skew);
    endtask

    task automatic test_last_cycle();
        int lat;
        mode = 3;
        do_start();
        wait_end(lat);
        mode = 0;
        total_cnt++; if (lat != LAT) $display("FAIL s4_latency: got %0d need %0d", lat, LAT); else pass_cnt++;
        total_cnt++; if (early_map !== 8'h08 || late_map !== 8'h08)
            $display("FAIL s4_maps: got %h/%h need 08/08", early_map, late_map); else pass_cnt++;
        total_cnt++; if (result !== 3'd2 || lane_width !== 3'd2)
            $display("FAIL s4_result: got res=%0d lane=%0d need 2 2", result, lane_width); else pass_cnt++;
        total_cnt++; if (skew !== 2'b11) $display("FAIL s4_skew: got %b need 11", skew); else pass_cnt++;
        $display("s4 last sample pulse: em=%h lm=%h result=%0d", early_map, late_map, result);
    endtask

    task automatic test_restart_reset();
        int lat;
        int n;
        mode = 0;
        clr_q.delete();
        do_start();
        repeat (19) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total_cnt++; if (lane_width !== 3'd2 || busy !== 1'b1)
            $display("FAIL s5_ignore_start: got lane=%0d busy=%b need 2 1", lane_width, busy); else pass_cnt++;
        total_cnt++; if (clr_q.size() != 3) $display("FAIL s5_clear_count: got %0d need 3", clr_q.size()); else pass_cnt++;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done, err, clear_flags, retrain, lane_width, result, early_map, late_map, skew} !== 29'd0)
            $display("FAIL s5_reset_outputs: got busy=%b done=%b err=%b clr=%b lw=%0d res=%0d, need all 0",
                     busy, done, err, clear_flags, lane_width, result);
        else pass_cnt++;
        n = clr_q.size();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total_cnt++; if (clr_q.size() != n || busy !== 1'b0)
            $display("FAIL s5_idle_after_abort: got pulses=%0d busy=%b need %0d 0", clr_q.size(), busy, n); else pass_cnt++;
        clr_q.delete();
        do_start();
        wait_end(lat);
        total_cnt++; if (lat != LAT || done !== 1'b1 || result !== 3'd7)
            $display("FAIL s5_resweep: got lat=%0d done=%b res=%0d need %0d 1 7", lat, done, result, LAT); else pass_cnt++;
        total_cnt++; if (clr_q.size() != 8 || clr_q[0] !== 3'd0)
            $display("FAIL s5_resweep_from0: got pulses=%0d first=%0d need 8 0", clr_q.size(), clr_q[0]); else pass_cnt++;
        $display("s5 restart/reset: resweep lat=%0d result=%0d", lat, result);
    endtask

`ifdef EYE_MON_CONT_TRACK_EN
    task automatic test_track();
        int bad;
        int seen;
        bad = 0;
        seen = -1;
        mode = 4;
        for (int i = 1; i <= 64 + 14; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1 || busy !== 1'b0 || lane_width !== 3'd7) bad++;
            if (retrain === 1'b1 && seen < 0) seen = i;
        end
        mode = 0;
        total_cnt++; if (seen < 0) $display("FAIL s6_retrain: got retrain=%b need 1 within 78 cycles", retrain); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL s6_done_hold: got %0d bad cycles need 0", bad); else pass_cnt++;
        $display("s6 tracking: retrain at +%0d", seen);
    endtask
`endif

    initial begin
        test_reset();
        test_no_flags();
`ifndef EYE_MON_CONT_TRACK_EN
        test_static_done();
`endif
        test_early_high();
        test_late_err();
        test_last_cycle();
        test_restart_reset();
`ifdef EYE_MON_CONT_TRACK_EN
        test_track();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
